// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the seven-segment display path: segment codes for
// the active-high common-cathode tubes (bit 7 = segment a ... bit 1 = g,
// bit 0 = dp), special nibble codes the mode blocks may send, source
// indices on the request vector, and the arbiter state type with two small
// helpers.
// ---------------------------------------------------------------------------
package display_pkg;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hE6;
  localparam logic [7:0] SEG_DASH  = 8'h02;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [3:0] BCD_DASH  = 4'hA;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  localparam int SRC_TIMER     = 0;
  localparam int SRC_COUNTDOWN = 1;
  localparam int SRC_ALERT     = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2,
    ARB_OWN2 = 2'd3
  } arbState_t;

  // Owner state for the highest-priority request currently raised, or IDLE
  // when nobody is asking.
  function automatic arbState_t highestReq(input logic [2:0] reqVec);
    if (reqVec[SRC_ALERT])          return ARB_OWN2;
    else if (reqVec[SRC_COUNTDOWN]) return ARB_OWN1;
    else if (reqVec[SRC_TIMER])     return ARB_OWN0;
    else                            return ARB_IDLE;
  endfunction

  // One-hot grant vector corresponding to an arbiter state.
  function automatic logic [2:0] grantOf(input arbState_t st);
    case (st)
      ARB_OWN0: return 3'b001;
      ARB_OWN1: return 3'b010;
      ARB_OWN2: return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// ---------------------------------------------------------------------------
// seg_decoder
// Combinational BCD nibble to seven-segment code. 0-9 map to digits, the
// dash code lights only segment g, everything else is blank.
//   nibble_i   : 4-bit BCD/special code
//   segments_o : 8-bit segment pattern
// ---------------------------------------------------------------------------
module seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] segments_o
);

  // Pure lookup; the default covers 4'hB..4'hF, including BCD_BLANK.
  always_comb begin
    segments_o = SEG_BLANK;
    case (nibble_i)
      4'd0:     segments_o = SEG_0;
      4'd1:     segments_o = SEG_1;
      4'd2:     segments_o = SEG_2;
      4'd3:     segments_o = SEG_3;
      4'd4:     segments_o = SEG_4;
      4'd5:     segments_o = SEG_5;
      4'd6:     segments_o = SEG_6;
      4'd7:     segments_o = SEG_7;
      4'd8:     segments_o = SEG_8;
      4'd9:     segments_o = SEG_9;
      BCD_DASH: segments_o = SEG_DASH;
      default:  segments_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// seg_display_arbiter
// Shares the 6-digit seven-segment display between the timer (req 0),
// countdown (req 1) and alert (req 2) sources. A fixed-priority arbiter with
// a minimum hold time picks the owner; this block also runs the digit scan
// and the BCD decode, so mode blocks only hand over BCD digits.
//   clk            : system clock
//   reset          : asynchronous, active-low
//   power_state    : 1 = on, 0 = synchronous clear of everything
//   req[2:0]       : request per source, bit 2 highest priority
//   digits0..2     : BCD digits per source, [23:20] leftmost
//   grant[2:0]     : one-hot current owner, 0 = none
//   tub_segments_1 : segment bus for digits 0-3
//   tub_segments_2 : segment bus for digits 4-5
//   tub_select     : one-hot digit enable, 6'b100000 = digit 0
// ---------------------------------------------------------------------------
module seg_display_arbiter
  import display_pkg::*;
#(
  parameter int SCAN_DIV    = 20000,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        power_state,
  input  logic [2:0]  req,
  input  logic [23:0] digits0,
  input  logic [23:0] digits1,
  input  logic [23:0] digits2,
  output logic [2:0]  grant,
  output logic [7:0]  tub_segments_1,
  output logic [7:0]  tub_segments_2,
  output logic [5:0]  tub_select
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  arbState_t         state_q, state_d;
  logic [2:0]        grant_q, grant_d;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
  logic [SCAN_W-1:0] scanCount_q, scanCount_d;
  logic [2:0]        scanIndex_q, scanIndex_d;
  logic [7:0]        seg1_q, seg1_d, seg2_q, seg2_d;
  logic [5:0]        tubSel_q, tubSel_d;

  logic              scanTick;
  logic [2:0]        aboveMask;
  logic [23:0]       srcDigits;
  logic [3:0]        slotNibble;
  logic [7:0]        slotSegments;

  assign scanTick = (scanCount_q == SCAN_LAST);

  // Requests strictly above the current owner. For owner 0 this is 3'b110,
  // owner 1 gives 3'b100, owner 2 (or idle, which never uses it) gives 0.
  assign aboveMask = ~((grant_q << 1) - 3'd1);

  // Grant arbitration: alert preempts at once, a dropped request releases at
  // once, and a higher-priority waiter only takes over after the hold time.
  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    if (!power_state) begin
      state_d   = ARB_IDLE;
      holdCnt_d = '0;
    end else if (state_q == ARB_IDLE) begin
      if (|req) begin
        state_d   = highestReq(req);
        holdCnt_d = HOLD_LOAD;
      end
    end else if (req[SRC_ALERT] && state_q != ARB_OWN2) begin
      state_d   = ARB_OWN2;
      holdCnt_d = HOLD_LOAD;
    end else if ((req & grant_q) == 3'b000) begin
      state_d   = highestReq(req);
      holdCnt_d = (|req) ? HOLD_LOAD : '0;
    end else if (holdCnt_q == '0 && (req & aboveMask) != 3'b000) begin
      state_d   = highestReq(req);
      holdCnt_d = HOLD_LOAD;
    end else if (holdCnt_q != '0) begin
      holdCnt_d = holdCnt_q - HOLD_W'(1);
    end
    grant_d = grantOf(state_d);
  end

  // The owner sampled at a scan tick picks the digit source for the whole
  // slot, so a grant change mid-slot never tears the digit being shown.
  always_comb begin
    srcDigits = '0;
    case (grant_q)
      3'b001:  srcDigits = digits0;
      3'b010:  srcDigits = digits1;
      3'b100:  srcDigits = digits2;
      default: srcDigits = '0;
    endcase
    case (scanIndex_q)
      3'd0:    slotNibble = srcDigits[23:20];
      3'd1:    slotNibble = srcDigits[19:16];
      3'd2:    slotNibble = srcDigits[15:12];
      3'd3:    slotNibble = srcDigits[11:8];
      3'd4:    slotNibble = srcDigits[7:4];
      default: slotNibble = srcDigits[3:0];
    endcase
  end

  seg_decoder u_decoder (
    .nibble_i   (slotNibble),
    .segments_o (slotSegments)
  );

  // Scan divider and output registers: outputs load only on the tick edge,
  // with the slot's digit routed to the bus that wires to that tube group.
  always_comb begin
    scanCount_d = scanCount_q + SCAN_W'(1);
    scanIndex_d = scanIndex_q;
    seg1_d      = seg1_q;
    seg2_d      = seg2_q;
    tubSel_d    = tubSel_q;
    if (!power_state) begin
      scanCount_d = '0;
      scanIndex_d = '0;
      seg1_d      = '0;
      seg2_d      = '0;
      tubSel_d    = '0;
    end else if (scanTick) begin
      scanCount_d = '0;
      scanIndex_d = (scanIndex_q == 3'd5) ? 3'd0 : scanIndex_q + 3'd1;
      tubSel_d    = 6'b100000 >> scanIndex_q;
      seg1_d      = '0;
      seg2_d      = '0;
      if (grant_q != 3'b000) begin
        if (scanIndex_q < 3'd4) seg1_d = slotSegments;
        else                    seg2_d = slotSegments;
      end
    end
  end

  // All state clears asynchronously so the tubes go dark the moment reset
  // is asserted, and the scan restarts from digit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      holdCnt_q   <= '0;
      scanCount_q <= '0;
      scanIndex_q <= '0;
      seg1_q      <= '0;
      seg2_q      <= '0;
      tubSel_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      holdCnt_q   <= holdCnt_d;
      scanCount_q <= scanCount_d;
      scanIndex_q <= scanIndex_d;
      seg1_q      <= seg1_d;
      seg2_q      <= seg2_d;
      tubSel_q    <= tubSel_d;
    end
  end

  assign grant          = grant_q;
  assign tub_segments_1 = seg1_q;
  assign tub_segments_2 = seg2_q;
  assign tub_select     = tubSel_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seg_display_arbiter
// Bench for seg_display_arbiter with SCAN_DIV=4 and HOLD_CYCLES=20. A
// cycle-level reference model of the sharing rules runs beside the DUT and
// is compared on every falling edge; directed scenarios add literal
// expectations, followed by a randomized request/power/digit phase.
// ---------------------------------------------------------------------------
module tb_seg_display_arbiter;

  localparam int SCAN_DIV = 4;
  localparam int HOLD     = 20;

  logic        clk         = 1'b0;
  logic        reset       = 1'b1;
  logic        power_state = 1'b0;
  logic [2:0]  req         = 3'b000;
  logic [23:0] digits0     = '0;
  logic [23:0] digits1     = '0;
  logic [23:0] digits2     = '0;
  logic [2:0]  grant;
  logic [7:0]  tub_segments_1;
  logic [7:0]  tub_segments_2;
  logic [5:0]  tub_select;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Reference model state: owner -1 means nobody holds the display.
  int         mOwner = -1;
  int         mHold  = 0;
  int         mCnt   = 0;
  int         mIdx   = 0;
  logic [7:0] mSeg1  = '0;
  logic [7:0] mSeg2  = '0;
  logic [5:0] mSel   = '0;

  seg_display_arbiter #(
    .SCAN_DIV    (SCAN_DIV),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .power_state    (power_state),
    .req            (req),
    .digits0        (digits0),
    .digits1        (digits1),
    .digits2        (digits2),
    .grant          (grant),
    .tub_segments_1 (tub_segments_1),
    .tub_segments_2 (tub_segments_2),
    .tub_select     (tub_select)
  );

  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] refDecode(input int nib);
    case (nib)
      0: return 8'hFC;  1: return 8'h60;  2: return 8'hDA;  3: return 8'hF2;
      4: return 8'h66;  5: return 8'hB6;  6: return 8'hBE;  7: return 8'hE0;
      8: return 8'hFE;  9: return 8'hE6;  10: return 8'h02;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [23:0] srcOf(input int owner);
    case (owner)
      0: return digits0;
      1: return digits1;
      default: return digits2;
    endcase
  endfunction

  function automatic int nibbleOf(input logic [23:0] d, input int k);
    logic [23:0] shifted;
    shifted = d >> ((5 - k) * 4);
    return int'(shifted[3:0]);
  endfunction

  function automatic int selToIdx(input logic [5:0] s);
    logic [5:0] pattern;
    for (int i = 0; i < 6; i++) begin
      pattern = 6'b100000 >> i;
      if (s == pattern) return i;
    end
    return -1;
  endfunction

  // Reference model: advances one clock at a time from the sharing rules,
  // using the owner as it stood before this edge for the scan slot.
  always @(posedge clk or negedge reset) begin
    int top;
    logic [7:0] code;
    if (!reset || !power_state) begin
      mOwner = -1; mHold = 0; mCnt = 0; mIdx = 0;
      mSeg1 = '0; mSeg2 = '0; mSel = '0;
    end else begin
      if (mCnt == SCAN_DIV - 1) begin
        mCnt = 0;
        mSel = 6'b100000 >> mIdx;
        code = (mOwner < 0) ? 8'h00 : refDecode(nibbleOf(srcOf(mOwner), mIdx));
        mSeg1 = (mIdx < 4) ? code : 8'h00;
        mSeg2 = (mIdx < 4) ? 8'h00 : code;
        mIdx = (mIdx + 1) % 6;
      end else begin
        mCnt++;
      end
      top = req[2] ? 2 : (req[1] ? 1 : (req[0] ? 0 : -1));
      if (mOwner < 0) begin
        if (top >= 0) begin mOwner = top; mHold = HOLD - 1; end
      end else if (req[2] && mOwner != 2) begin
        mOwner = 2; mHold = HOLD - 1;
      end else if (!req[mOwner]) begin
        mOwner = top; mHold = (top >= 0) ? HOLD - 1 : 0;
      end else if (mHold == 0 && top > mOwner) begin
        mOwner = top; mHold = HOLD - 1;
      end else if (mHold > 0) begin
        mHold--;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    logic [2:0] expGrant;
    if (checkEn) begin
      expGrant = (mOwner < 0) ? 3'b000 : 3'(1 << mOwner);
      checks++;
      if (grant !== expGrant || tub_segments_1 !== mSeg1 ||
          tub_segments_2 !== mSeg2 || tub_select !== mSel) begin
        errors++;
        $display("[TB] FAIL model_compare t=%0t: grant got %b exp %b, seg1 got %h exp %h, seg2 got %h exp %h, sel got %b exp %b",
                 $time, grant, expGrant, tub_segments_1, mSeg1, tub_segments_2, mSeg2, tub_select, mSel);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic pwr, input logic [2:0] r);
    power_state = pwr;
    req         = r;
  endtask

  // Wait (bounded) for the next digit slot to appear on tub_select.
  task automatic nextSlot(output int waited);
    logic [5:0] prevSel;
    prevSel = tub_select;
    waited  = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (tub_select == prevSel && waited < 4 * SCAN_DIV);
    checkOutput("slot_advance", 32'(tub_select != prevSel), 32'd1);
  endtask

  // Check six consecutive slots against per-digit literal codes.
  task automatic checkSixSlots(input string tag, input logic [7:0] expCodes [6]);
    int waited;
    int k;
    for (int s = 0; s < 6; s++) begin
      nextSlot(waited);
      k = selToIdx(tub_select);
      checkOutput({tag, "_sel_onehot"}, 32'(k >= 0), 32'd1);
      if (k >= 0 && k < 4) begin
        checkOutput({tag, "_seg1"}, 32'(tub_segments_1), 32'(expCodes[k]));
        checkOutput({tag, "_seg2"}, 32'(tub_segments_2), 32'd0);
      end else if (k >= 4) begin
        checkOutput({tag, "_seg2"}, 32'(tub_segments_2), 32'(expCodes[k]));
        checkOutput({tag, "_seg1"}, 32'(tub_segments_1), 32'd0);
      end
    end
  endtask

  initial begin
    int waited;
    int n;
    logic [5:0] expSel;
    logic [7:0] singleCodes [6];
    logic [7:0] edgeCodes [6];
    singleCodes = '{8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE};
    edgeCodes   = '{8'h02, 8'hFC, 8'h00, 8'h00, 8'hE6, 8'h02};

    // Reset and idle scan.
    #1 reset = 1'b0;
    #1 checkEn = 1'b1;
    applyStimulus(1'b1, 3'b000);
    repeat (2) @(negedge clk);
    checkOutput("reset_grant", 32'(grant), 32'd0);
    checkOutput("reset_sel", 32'(tub_select), 32'd0);
    checkOutput("reset_seg1", 32'(tub_segments_1), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nextSlot(waited);
      expSel = 6'b100000 >> i;
      checkOutput("idle_sel", 32'(tub_select), 32'(expSel));
      checkOutput("idle_segs", 32'({tub_segments_1, tub_segments_2}), 32'd0);
      if (i > 0) checkOutput("idle_slot_period", 32'(waited), 32'(SCAN_DIV));
    end
    checkOutput("idle_grant", 32'(grant), 32'd0);

    // Single owner display.
    digits0 = 24'h123456;
    digits1 = 24'h654321;
    digits2 = 24'h987654;
    applyStimulus(1'b1, 3'b001);
    @(negedge clk);
    checkOutput("single_grant", 32'(grant), 32'b001);
    checkSixSlots("single", singleCodes);

    // Hold enforcement: fresh grant to owner 0, countdown raised later.
    applyStimulus(1'b1, 3'b000);
    @(negedge clk);
    checkOutput("hold_released", 32'(grant), 32'd0);
    applyStimulus(1'b1, 3'b001);
    @(negedge clk);
    checkOutput("hold_grant0", 32'(grant), 32'b001);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 4) applyStimulus(1'b1, 3'b011);
    end while (grant != 3'b010 && n < 60);
    checkOutput("hold_switch_cycles", 32'(n), 32'd20);

    // Alert preemption mid-hold, then release back to countdown.
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 3'b110);
    @(negedge clk);
    checkOutput("preempt_grant", 32'(grant), 32'b100);
    applyStimulus(1'b1, 3'b010);
    @(negedge clk);
    checkOutput("release_grant", 32'(grant), 32'b010);

    // Decode edge cases on owner 0 (countdown drops, timer takes over).
    digits0 = 24'hA0FB9A;
    applyStimulus(1'b1, 3'b001);
    @(negedge clk);
    checkOutput("edge_grant", 32'(grant), 32'b001);
    checkSixSlots("decode_edge", edgeCodes);

    // Power off while alert is displayed, then power back on.
    applyStimulus(1'b1, 3'b100);
    @(negedge clk);
    checkOutput("alert_grant", 32'(grant), 32'b100);
    nextSlot(waited);
    nextSlot(waited);
    applyStimulus(1'b0, 3'b100);
    @(negedge clk);
    checkOutput("poweroff_grant", 32'(grant), 32'd0);
    checkOutput("poweroff_sel", 32'(tub_select), 32'd0);
    checkOutput("poweroff_segs", 32'({tub_segments_1, tub_segments_2}), 32'd0);
    applyStimulus(1'b1, 3'b100);
    @(negedge clk);
    checkOutput("poweron_grant", 32'(grant), 32'b100);
    nextSlot(waited);
    checkOutput("poweron_first_sel", 32'(tub_select), 32'(6'b100000));
    checkOutput("poweron_first_seg1", 32'(tub_segments_1), 32'h00E6);
    checkOutput("poweron_first_wait", 32'(waited), 32'd3);

    // Randomized phase with the model checking every cycle.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) digits0 = 24'($urandom);
      if ($urandom_range(0, 15) == 0) digits1 = 24'($urandom);
      if ($urandom_range(0, 15) == 0) digits2 = 24'($urandom);
      if (power_state && $urandom_range(0, 199) == 0) power_state = 1'b0;
      else if (!power_state && $urandom_range(0, 2) == 0) power_state = 1'b1;
      if (c == 1000) begin
        #2 reset = 1'b0;
        #1 checkOutput("async_reset_sel", 32'(tub_select), 32'd0);
        checkOutput("async_reset_grant", 32'(grant), 32'd0);
        @(negedge clk);
        reset = 1'b1;
      end
    end

    @(negedge clk);
    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares the single 6-digit seven-segment display between three content sources: clock/timer (req 0), countdown (req 1) and alert/message (req 2).
- Grants the display to one requester using fixed priority and a minimum hold time.
- Owns the multiplex scan and the BCD-to-segment decode.
- Sits between the mode blocks and the board display pins. Mode blocks supply BCD digits only and no longer drive segments.

Parameters:
- SCAN_DIV, 20000: clk cycles per digit slot.
- HOLD_CYCLES, 100000000: minimum grant duration, 1 s at 100 MHz.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low
- power_state  in  1  1 = device on; 0 forces idle/blank
- req  in  3  request per source; bit 2 is highest priority
- digits0  in  24  source 0 BCD digits, [23:20] leftmost … [3:0] rightmost
- digits1  in  24  source 1 BCD digits
- digits2  in  24  source 2 BCD digits
- grant  out  3  one-hot current owner; 0 = none
- tub_segments_1  out  8  segment bus, digits 0-3
- tub_segments_2  out  8  segment bus, digits 4-5
- tub_select  out  6  one-hot digit enable, 6'b100000 = digit 0

Behaviour:
- Reset (async, reset=0): state IDLE, grant=0, both segment buses 0, tub_select=0, scan_counter=0, scan_index=0, hold_cnt=0.
- power_state=0: same clear applied synchronously every cycle. Inputs are ignored until power_state=1.
- Grant FSM states: IDLE and OWN(i).
- IDLE: if any req is set, go next cycle to OWN(highest set bit), load hold_cnt=HOLD_CYCLES-1, grant registered.
- OWN(i), evaluated in this order each cycle:
  - If req[2]=1 and i≠2: preempt immediately to OWN(2), reload hold_cnt.
  - Else if req[i]=0: release immediately. Go to OWN(highest other set req) with reload, or to IDLE if none.
  - Else if hold_cnt=0 and a higher-priority req is set: switch to it, reload.
  - Else stay; hold_cnt decrements, saturating at 0.
- A lower-priority request never preempts. Equal-priority contention cannot occur.
- Grant changes take effect on grant 1 cycle after the deciding edge.
- Scan:
  - scan_counter counts 0..SCAN_DIV-1 and wraps.
  - On the wrap cycle, scan_index advances 0→5→0 and the output registers load in the same edge.
  - Segments/select update exactly 1 cycle after the tick. Between ticks the outputs are held.
- Displayed digit source:
  - The latched owner at the tick (owner_disp) selects the source.
  - owner_disp updates only on scan ticks, so a grant change never tears a digit slot mid-period.
- Output mapping per scan_index k:
  - tub_select = 6'b100000 >> k.
  - k=0..3: tub_segments_1 = decode(nibble k), tub_segments_2 = 0.
  - k=4,5: tub_segments_2 = decode(nibble k), tub_segments_1 = 0.
- Decode table:
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=E6 (hex).
  - 4'hA = dash 8'h02.
  - 4'hB..4'hF = blank 8'h00.
- IDLE/no owner: scanning continues, segments 0, tub_select still walks.
- Reset mid-scan: the outputs clear immediately (async), and the scan restarts at digit 0.

Decomposition:
- Package display_pkg holds:
  - segment code constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK
  - nibble codes BCD_DASH=4'hA, BCD_BLANK=4'hF
  - source indices SRC_TIMER=0, SRC_COUNTDOWN=1, SRC_ALERT=2
- One sub-module seg_decoder: combinational 4-bit nibble to 8-bit segment code. It is instantiated once on the muxed nibble.
- The arbiter FSM and scan counter stay in the top module.

Test Plan (bench: SCAN_DIV=4, HOLD_CYCLES=20):
- Reset/idle: reset low, then high with req=0. Required: grant=0, segments 0 throughout, tub_select walks 100000→000001 every 4 cycles, first change 1 cycle after the tick.
- Single owner display: req=001, digits0=24'h123456. Required: grant=001 next cycle; across the next 6 ticks tub_segments_1 = 60, DA, F2, 66 then tub_segments_2 = B6, BE, with the other bus 0.
- Hold enforcement: owner 0 granted, then req=011 raised 5 cycles later. Required: grant stays 001 until hold_cnt reaches 0 (20 cycles after the grant), then grant=010. Digit content switches only at the next tick.
- Alert preemption and release: owner 1 active, req[2] raised mid-hold. Required: grant=100 next cycle. Drop req[2] with req[1] still high: grant=010 next cycle.
- Decode edges: digits0=24'hA0FB9A. Required: codes 02, FC, 00, 00, E6, 02.
- Power off mid-operation: power_state=0 while owner 2 is displayed. Required: next cycle grant=0, all outputs 0. power_state=1 with req=100: grant=100, and the scan restarts at digit 0.
